// File: rtl/apu_length_envelope.sv
// Per-channel envelope generator and length counter for the APU tone channels.
// Write strobes are edge-detected; e_pulse/l_pulse come from the frame counter.
module apu_length_envelope #(
  parameter int HAS_ENVELOPE = 1,
  parameter int HALT_BIT     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e_pulse,
  input  logic       l_pulse,
  input  logic [7:0] ctrl_data,
  input  logic       ctrl_wren,
  input  logic [4:0] len_data,
  input  logic       len_wren,
  input  logic       chan_enable,
  output logic [3:0] env_volume,
  output logic       length_active,
  output logic [7:0] length_count
);

  logic       prev_ctrl_wren, prev_len_wren;
  logic       ctrl_edge, len_edge;
  logic [7:0] length_q, length_d;
  logic [3:0] decay_q, decay_d;
  logic [3:0] divider_q, divider_d;
  logic       start_q, start_d;
  logic       halt_q, halt_d;
  logic       const_vol_q, const_vol_d;
  logic [3:0] vol_q, vol_d;
  logic [3:0] env_q, env_d;

  function automatic logic [7:0] len_table(input logic [4:0] idx);
    case (idx)
      5'd0:  len_table = 8'd10;   5'd1:  len_table = 8'd254;
      5'd2:  len_table = 8'd20;   5'd3:  len_table = 8'd2;
      5'd4:  len_table = 8'd40;   5'd5:  len_table = 8'd4;
      5'd6:  len_table = 8'd80;   5'd7:  len_table = 8'd6;
      5'd8:  len_table = 8'd160;  5'd9:  len_table = 8'd8;
      5'd10: len_table = 8'd60;   5'd11: len_table = 8'd10;
      5'd12: len_table = 8'd14;   5'd13: len_table = 8'd12;
      5'd14: len_table = 8'd26;   5'd15: len_table = 8'd14;
      5'd16: len_table = 8'd12;   5'd17: len_table = 8'd16;
      5'd18: len_table = 8'd24;   5'd19: len_table = 8'd18;
      5'd20: len_table = 8'd48;   5'd21: len_table = 8'd20;
      5'd22: len_table = 8'd96;   5'd23: len_table = 8'd22;
      5'd24: len_table = 8'd192;  5'd25: len_table = 8'd24;
      5'd26: len_table = 8'd72;   5'd27: len_table = 8'd26;
      5'd28: len_table = 8'd16;   5'd29: len_table = 8'd28;
      5'd30: len_table = 8'd32;   default: len_table = 8'd30;
    endcase
  endfunction

  // Strobes are level signals that may be held; only the rising edge acts.
  assign ctrl_edge = ctrl_wren && !prev_ctrl_wren;
  assign len_edge  = len_wren && !prev_len_wren;

  always_comb begin
    length_d    = length_q;
    decay_d     = decay_q;
    divider_d   = divider_q;
    start_d     = start_q;
    halt_d      = halt_q;
    const_vol_d = const_vol_q;
    vol_d       = vol_q;
    env_d       = 4'h0;

    // Decrement uses the registered halt; load overrides; disable overrides all.
    if (l_pulse && (length_q != 8'd0) && !halt_q)
      length_d = length_q - 8'd1;
    if (len_edge)
      length_d = len_table(len_data);
    if (!chan_enable)
      length_d = 8'd0;

    if (ctrl_edge) begin
      halt_d      = ctrl_data[HALT_BIT];
      const_vol_d = ctrl_data[4];
      vol_d       = ctrl_data[3:0];
    end

    if (HAS_ENVELOPE != 0) begin
      if (e_pulse) begin
        if (start_q) begin
          start_d   = 1'b0;
          decay_d   = 4'hF;
          divider_d = vol_q;
        end else if (divider_q == 4'h0) begin
          divider_d = vol_q;
          if (decay_q != 4'h0)
            decay_d = decay_q - 4'h1;
          else if (halt_q)
            decay_d = 4'hF;
        end else begin
          divider_d = divider_q - 4'h1;
        end
      end
      // A same-cycle length write re-arms start even if e_pulse just cleared it.
      if (len_edge)
        start_d = 1'b1;
      env_d = const_vol_q ? vol_q : decay_q;
    end else begin
      decay_d   = 4'h0;
      divider_d = 4'h0;
      start_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Capturing the live strobe makes a strobe held across reset release inert.
      prev_ctrl_wren <= ctrl_wren;
      prev_len_wren  <= len_wren;
      length_q       <= 8'd0;
      decay_q        <= 4'h0;
      divider_q      <= 4'h0;
      start_q        <= 1'b0;
      halt_q         <= 1'b0;
      const_vol_q    <= 1'b0;
      vol_q          <= 4'h0;
      env_q          <= 4'h0;
    end else begin
      prev_ctrl_wren <= ctrl_wren;
      prev_len_wren  <= len_wren;
      length_q       <= length_d;
      decay_q        <= decay_d;
      divider_q      <= divider_d;
      start_q        <= start_d;
      halt_q         <= halt_d;
      const_vol_q    <= const_vol_d;
      vol_q          <= vol_d;
      env_q          <= env_d;
    end
  end

  assign env_volume    = env_q;
  assign length_count  = length_q;
  assign length_active = (length_q != 8'd0);

endmodule

// File: tb/tb_apu_length_envelope.sv
// Directed bench for apu_length_envelope: length counter, halt, envelope decay/loop,
// constant volume, channel disable and write-strobe edge behaviour.
module tb_apu_length_envelope;

  logic       clk = 1'b0;
  logic       rst;
  logic       e_pulse, l_pulse;
  logic [7:0] ctrl_data;
  logic       ctrl_wren;
  logic [4:0] len_data;
  logic       len_wren;
  logic       chan_enable;
  logic [3:0] env_volume;
  logic       length_active;
  logic [7:0] length_count;

  int checks = 0;
  int errors = 0;

  apu_length_envelope #(.HAS_ENVELOPE(1), .HALT_BIT(5)) dut (
    .clk(clk), .rst(rst), .e_pulse(e_pulse), .l_pulse(l_pulse),
    .ctrl_data(ctrl_data), .ctrl_wren(ctrl_wren), .len_data(len_data),
    .len_wren(len_wren), .chan_enable(chan_enable), .env_volume(env_volume),
    .length_active(length_active), .length_count(length_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic len_write(input logic [4:0] idx);
    len_data = idx; len_wren = 1'b1; step();
    len_wren = 1'b0; step();
  endtask

  task automatic ctrl_write(input logic [7:0] d);
    ctrl_data = d; ctrl_wren = 1'b1; step();
    ctrl_wren = 1'b0; step();
  endtask

  task automatic lpulses(input int n);
    for (int i = 0; i < n; i++) begin
      l_pulse = 1'b1; step();
      l_pulse = 1'b0; step();
    end
  endtask

  task automatic epulses(input int n);
    for (int i = 0; i < n; i++) begin
      e_pulse = 1'b1; step();
      e_pulse = 1'b0; step();
    end
  endtask

  initial begin
    rst = 1'b1; e_pulse = 1'b0; l_pulse = 1'b0; ctrl_data = 8'h00; ctrl_wren = 1'b0;
    len_data = 5'd0; len_wren = 1'b0; chan_enable = 1'b1;
    step(3);
    rst = 1'b0;
    step();
    check("reset_length", length_count, 0);
    check("reset_active", length_active, 0);
    check("reset_env", env_volume, 0);

    // Length counter full run from 254
    len_write(5'd1);
    check("len_load_254", length_count, 254);
    check("len_active_254", length_active, 1);
    lpulses(1);
    check("len_dec_253", length_count, 253);
    lpulses(253);
    check("len_zero", length_count, 0);
    check("len_inactive", length_active, 0);
    lpulses(3);
    check("len_no_wrap", length_count, 0);

    // Halt freezes the counter
    ctrl_write(8'h20);
    len_write(5'd0);
    check("halt_load_10", length_count, 10);
    lpulses(5);
    check("halt_hold", length_count, 10);
    ctrl_write(8'h00);
    lpulses(5);
    check("unhalt_dec", length_count, 5);

    // Envelope decay, period 3
    ctrl_write(8'h03);
    len_write(5'd2);
    epulses(1);
    check("env_start_15", env_volume, 15);
    epulses(3);
    check("env_still_15", env_volume, 15);
    epulses(1);
    check("env_14", env_volume, 14);
    epulses(4);
    check("env_13", env_volume, 13);
    epulses(4 * 13);
    check("env_0", env_volume, 0);
    epulses(8);
    check("env_hold_0", env_volume, 0);
    ctrl_write(8'h23);
    epulses(3);
    check("env_loop_pre", env_volume, 0);
    epulses(1);
    check("env_loop_15", env_volume, 15);

    // Constant volume
    ctrl_write(8'h1A);
    check("const_10", env_volume, 10);
    epulses(7);
    check("const_10_pulsed", env_volume, 10);

    // Channel disable
    len_write(5'd2);
    check("dis_load_20", length_count, 20);
    chan_enable = 1'b0; step();
    chan_enable = 1'b1; step();
    check("dis_cleared", length_count, 0);
    chan_enable = 1'b0;
    len_write(5'd4);
    check("dis_load_drop", length_count, 0);
    chan_enable = 1'b1; step();

    // Load and l_pulse in the same clk: load wins
    len_write(5'd2);
    len_data = 5'd8; len_wren = 1'b1; l_pulse = 1'b1; step();
    len_wren = 1'b0; l_pulse = 1'b0; step();
    check("load_beats_dec", length_count, 160);

    // Held strobes act once
    len_data = 5'd1; len_wren = 1'b1; step();
    check("held_len_first", length_count, 254);
    l_pulse = 1'b1; step();
    l_pulse = 1'b0; step(3);
    check("held_len_once", length_count, 253);
    len_wren = 1'b0; step();
    ctrl_data = 8'h15; ctrl_wren = 1'b1; step();
    ctrl_data = 8'h1C; step(9);
    ctrl_wren = 1'b0; step();
    check("held_ctrl_once", env_volume, 5);

    // Mid-run reset with strobe held across release
    rst = 1'b1; len_data = 5'd1; len_wren = 1'b1; step(2);
    rst = 1'b0; step(3);
    check("rst_held_len", length_count, 0);
    check("rst_env", env_volume, 0);
    len_wren = 1'b0; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
